asrv32_fsm_hs: RTL
==================

// Module: asrv32_fsm_hs
// PURPOSE
// - Multicycle control FSM for the unpipelined ASRV32 core: FETCH/DECODE/EXECUTE/MEMORYACCESS/WRITEBACK.
// - Adds req/ack handshakes to instruction and data memory, a bus-timeout abort and a pipeline-hold input.
// - Adds a retired-instruction counter. Drives ALU operands and per-stage enables to the datapath.
// PARAMETERS
// - XLEN        32  datapath width (inst, pc, rs1/rs2, imm, operands)
// - BUS_TIMEOUT 16  max cycles a req waits for ack before abort; 0 = timeout disabled
// - TMO_W       5   width of wait counter; must hold BUS_TIMEOUT
// - CNT_W       32  width of retired-instruction counter
// PORTS
// - i_clk                   in   1              clock, rising edge
// - i_rst_n                 in   1              asynchronous active-low reset
// - i_inst                  in   XLEN           instruction from imem, sampled on fetch ack
// - i_pc                    in   XLEN           current program counter
// - i_rs1_data              in   XLEN           rs1 value
// - i_rs2_data              in   XLEN           rs2 value
// - i_imm                   in   XLEN           decoded immediate
// - i_opcode                in   `OPCODE_WIDTH  one-hot opcode, `OPCODE_* indices
// - i_stall                 in   1              hold request; honoured in DECODE/EXECUTE/WRITEBACK only
// - i_imem_ack              in   1              imem has i_inst valid this cycle
// - i_dmem_ack              in   1              dmem access complete this cycle
// - o_inst_q                out  XLEN           registered instruction
// - o_stage_q               out  3              current stage
// - o_op1                   out  XLEN           ALU op1: i_pc for JAL/AUIPC, else rs1; 0 outside EXECUTE
// - o_op2                   out  XLEN           ALU op2: rs2 for RTYPE/BRANCH, else imm; 0 outside EXECUTE
// - o_imem_req              out  1              stage==FETCH
// - o_dmem_req              out  1              stage==MEMORYACCESS && (LOAD||STORE)
// - o_dmem_we               out  1              o_dmem_req && STORE
// - o_alu_stage_en          out  1              stage==EXECUTE && !i_stall
// - o_memoryaccess_stage_en out  1              stage==MEMORYACCESS
// - o_writeback_stage_en    out  1              stage==WRITEBACK && !i_stall
// - o_bus_err               out  1              one-cycle pulse after a timeout abort
// - o_instret               out  CNT_W          retired-instruction count
// BEHAVIOUR
// - Reset (async): stage=FETCH(0), o_inst_q=0, wait counter=0, o_bus_err=0, o_instret=0.
// - Encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORYACCESS=3, WRITEBACK=4. Codes 5-7 go to FETCH next cycle.
// - FETCH: hold until i_imem_ack=1. On ack: o_inst_q<=i_inst, go to DECODE. o_inst_q is held otherwise.
// - DECODE->EXECUTE->MEMORYACCESS->WRITEBACK->FETCH: one cycle each unless stalled.
// - i_stall=1 freezes DECODE, EXECUTE and WRITEBACK. It is ignored in FETCH and MEMORYACCESS.
// - MEMORYACCESS, LOAD/STORE: hold until i_dmem_ack=1, then go to WRITEBACK.
// - MEMORYACCESS, other opcodes: one cycle, no req.
// - Leaving WRITEBACK (not stalled): o_instret+1, wraps modulo 2^CNT_W.
// - Wait counter: +1 each cycle o_imem_req or o_dmem_req is high without ack. Clears on ack or stage change.
// - Timeout: with BUS_TIMEOUT>0, if BUS_TIMEOUT cycles of a req pass with no ack, the FSM aborts:
//   - stage<=FETCH, counter<=0, o_bus_err=1 for the following cycle.
//   - o_instret and o_inst_q are not updated.
//   - An abort in FETCH restarts the fetch, with req continuously high.
// - Ack on the same cycle as the timeout: ack wins, no error.
// - Acks outside the matching wait state are ignored.
// - Reset asserted mid-handshake: immediate return to reset values. Pending req drops asynchronously.
// CONFIGURATION
// - Macro ASRV32_FSM_STAGE_SKIP_EN.
// - Defined: EXECUTE goes directly to WRITEBACK for non-LOAD/STORE opcodes.
//   - Non-memory instruction = 4 cycles plus fetch wait.
// - Undefined: every instruction passes through MEMORYACCESS.
//   - Non-memory instruction = 5 cycles plus fetch wait; the state sequence is the full 5-stage loop.
// TESTING
// - ADDI, imem ack in the 1st FETCH cycle, no stall:
//   - stages 0,1,2,3,4,0 (skip off) or 0,1,2,4,0 (skip on).
//   - o_instret 0->1; o_op2=i_imm in EXECUTE.
// - LW, dmem ack held off 3 cycles:
//   - o_dmem_req=1, o_dmem_we=0 for 4 MEMORYACCESS cycles, then WRITEBACK.
// - SW, BUS_TIMEOUT=16, no dmem ack:
//   - req high 16 cycles, then stage=FETCH, o_bus_err=1 for 1 cycle, o_instret unchanged.
// - i_stall=1 for 3 cycles entering EXECUTE:
//   - stage stays 2, o_alu_stage_en=0.
//   - On release, exactly one EXECUTE-enabled cycle; o_op1=i_pc for AUIPC.
// - CNT_W=4, 16 retirements: o_instret wraps 15->0.
// - i_rst_n pulsed low in MEMORYACCESS with dmem req pending:
//   - outputs return to reset values same cycle, o_dmem_req=0.
// - Ack arrives on the timeout cycle: transition taken, o_bus_err stays 0.

Source files
------------

// File: rtl/asrv32_fsm_hs.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORYACCESS/WRITEBACK control FSM with imem/dmem req/ack handshakes.
// Latency: one cycle per stage; FETCH and LOAD/STORE MEMORYACCESS wait for ack, and abort after BUS_TIMEOUT cycles.
// Backpressure: i_stall freezes DECODE/EXECUTE/WRITEBACK. Define ASRV32_FSM_STAGE_SKIP_EN to skip MEMORYACCESS for non-memory ops.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef OPCODE_RTYPE
`define OPCODE_RTYPE 0
`endif
`ifndef OPCODE_ITYPE
`define OPCODE_ITYPE 1
`endif
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 2
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 3
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH 4
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL 5
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR 6
`endif
`ifndef OPCODE_LUI
`define OPCODE_LUI 7
`endif
`ifndef OPCODE_AUIPC
`define OPCODE_AUIPC 8
`endif
`ifndef OPCODE_SYSTEM
`define OPCODE_SYSTEM 9
`endif
`ifndef OPCODE_FENCE
`define OPCODE_FENCE 10
`endif

module asrv32_fsm_hs #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [XLEN-1:0]          i_inst,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_rs1_data,
  input  logic [XLEN-1:0]          i_rs2_data,
  input  logic [XLEN-1:0]          i_imm,
  input  logic [`OPCODE_WIDTH-1:0] i_opcode,
  input  logic                     i_stall,
  input  logic                     i_imem_ack,
  input  logic                     i_dmem_ack,
  output logic [XLEN-1:0]          o_inst_q,
  output logic [2:0]               o_stage_q,
  output logic [XLEN-1:0]          o_op1,
  output logic [XLEN-1:0]          o_op2,
  output logic                     o_imem_req,
  output logic                     o_dmem_req,
  output logic                     o_dmem_we,
  output logic                     o_alu_stage_en,
  output logic                     o_memoryaccess_stage_en,
  output logic                     o_writeback_stage_en,
  output logic                     o_bus_err,
  output logic [CNT_W-1:0]         o_instret
);

  typedef enum logic [2:0] {
    FETCH        = 3'd0,
    DECODE       = 3'd1,
    EXECUTE      = 3'd2,
    MEMORYACCESS = 3'd3,
    WRITEBACK    = 3'd4
  } stage_e;

  // The wait counter is compared against BUS_TIMEOUT-1: the abort fires on
  // the BUS_TIMEOUT-th unacknowledged req cycle.
  localparam bit          TMO_EN     = (BUS_TIMEOUT > 0);
  localparam int unsigned TMO_LAST_I = TMO_EN ? (BUS_TIMEOUT - 1) : 0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];

  stage_e            stage;
  stage_e            stage_nxt;
  logic [XLEN-1:0]   inst_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TMO_W-1:0]  tmo_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  instret_nxt;

  logic is_rtype, is_branch, is_jal, is_auipc, is_load, is_store, is_mem;
  logic req_wait, tmo_hit;

  // Only a subset of opcode bits steers this FSM; the rest belong to the datapath.
  logic unused_opcode;
  assign unused_opcode = ^{i_opcode[`OPCODE_ITYPE], i_opcode[`OPCODE_JALR], i_opcode[`OPCODE_LUI],
                           i_opcode[`OPCODE_SYSTEM], i_opcode[`OPCODE_FENCE]};

  assign is_rtype  = i_opcode[`OPCODE_RTYPE];
  assign is_branch = i_opcode[`OPCODE_BRANCH];
  assign is_jal    = i_opcode[`OPCODE_JAL];
  assign is_auipc  = i_opcode[`OPCODE_AUIPC];
  assign is_load   = i_opcode[`OPCODE_LOAD];
  assign is_store  = i_opcode[`OPCODE_STORE];
  assign is_mem    = is_load | is_store;

  // Stage-decoded outputs are purely combinational from the state register,
  // so an async reset drops any pending req in the same cycle.
  always_comb begin
    o_imem_req              = (stage == FETCH);
    o_dmem_req              = (stage == MEMORYACCESS) && is_mem;
    o_dmem_we               = o_dmem_req && is_store;
    o_alu_stage_en          = (stage == EXECUTE) && !i_stall;
    o_memoryaccess_stage_en = (stage == MEMORYACCESS);
    o_writeback_stage_en    = (stage == WRITEBACK) && !i_stall;
    o_op1                   = '0;
    o_op2                   = '0;
    if (stage == EXECUTE) begin
      o_op1 = (is_jal || is_auipc)    ? i_pc       : i_rs1_data;
      o_op2 = (is_rtype || is_branch) ? i_rs2_data : i_imm;
    end
  end

  assign o_stage_q = stage;

  // A req cycle without its matching ack; acks in any other stage are ignored.
  assign req_wait = (o_imem_req && !i_imem_ack) || (o_dmem_req && !i_dmem_ack);
  assign tmo_hit  = TMO_EN && req_wait && (tmo_cnt == TMO_LAST);

  // Next-state, instruction capture, retire count and timeout abort.
  always_comb begin
    stage_nxt   = stage;
    inst_nxt    = o_inst_q;
    instret_nxt = o_instret;
    err_nxt     = 1'b0;
    tmo_nxt     = '0;
    case (stage)
      FETCH: begin
        if (i_imem_ack) begin
          inst_nxt  = i_inst;
          stage_nxt = DECODE;
        end
      end
      DECODE: begin
        if (!i_stall) stage_nxt = EXECUTE;
      end
      EXECUTE: begin
        if (!i_stall) begin
`ifdef ASRV32_FSM_STAGE_SKIP_EN
          stage_nxt = is_mem ? MEMORYACCESS : WRITEBACK;
`else
          stage_nxt = MEMORYACCESS;
`endif
        end
      end
      MEMORYACCESS: begin
        if (!is_mem || i_dmem_ack) stage_nxt = WRITEBACK;
      end
      WRITEBACK: begin
        if (!i_stall) begin
          stage_nxt   = FETCH;
          instret_nxt = o_instret + 1'b1;
        end
      end
      default: stage_nxt = FETCH;
    endcase

    // Abort: no ack is present here, so inst and instret are already untouched.
    if (tmo_hit) begin
      stage_nxt = FETCH;
      err_nxt   = 1'b1;
    end

    // Counter runs only while the same req is waiting; saturates when timeout is disabled.
    if (req_wait && !tmo_hit && (stage_nxt == stage) && (tmo_cnt != {TMO_W{1'b1}}))
      tmo_nxt = tmo_cnt + 1'b1;
    else if (req_wait && !tmo_hit && (stage_nxt == stage))
      tmo_nxt = tmo_cnt;
  end

  // State and datapath-control registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage     <= FETCH;
      o_inst_q  <= '0;
      tmo_cnt   <= '0;
      o_bus_err <= 1'b0;
      o_instret <= '0;
    end else begin
      stage     <= stage_nxt;
      o_inst_q  <= inst_nxt;
      tmo_cnt   <= tmo_nxt;
      o_bus_err <= err_nxt;
      o_instret <= instret_nxt;
    end
  end

endmodule
